// File: rtl/float_copro_seq.sv
// LM32 float coprocessor: the float_pack arithmetic package plus the sequencing/execution stage.
// Add/sub/mul come from package functions, pipelined to a fixed latency; divide is a serial restoring divider.
package float_pack;
    localparam int N_exposant = 8;
    localparam int N_mantisse = 23;
    localparam int W          = 1 + N_exposant + N_mantisse;

    typedef struct packed {
        logic                  signe;
        logic [N_exposant-1:0] exposant;
        logic [N_mantisse-1:0] mantisse;
    } float;

    localparam logic signed [N_exposant+1:0] E_ZERO = '0;
    localparam logic signed [N_exposant+1:0] E_ONE  = (N_exposant+2)'(1);
    localparam logic signed [N_exposant+1:0] E_BIAS = (N_exposant+2)'(2**(N_exposant-1)-1);
    localparam logic signed [N_exposant+1:0] E_SAT  = (N_exposant+2)'(2**N_exposant-2);

    // Final range check shared by all operators: underflow flushes to zero, overflow saturates.
    function automatic float float_pack_res(input logic s, input logic signed [N_exposant+1:0] e,
                                            input logic [N_mantisse-1:0] m);
        float r;
        r.signe = s;
        if (e <= E_ZERO) begin
            r.exposant = '0;
            r.mantisse = '0;
        end else if (e > E_SAT) begin
            r.exposant = E_SAT[N_exposant-1:0];
            r.mantisse = '1;
        end else begin
            r.exposant = e[N_exposant-1:0];
            r.mantisse = m;
        end
        return r;
    endfunction

    function automatic float float_mul(input float a, input float b);
        logic [2*N_mantisse+1:0]   p;
        logic signed [N_exposant+1:0] e;
        logic [N_mantisse-1:0]     m;
        float                      r;
        p = {1'b1, a.mantisse} * {1'b1, b.mantisse};
        e = $signed({2'b00, a.exposant}) + $signed({2'b00, b.exposant}) - E_BIAS;
        if (p[2*N_mantisse+1]) begin
            m = p[2*N_mantisse:N_mantisse+1];
            e = e + E_ONE;
        end else begin
            m = p[2*N_mantisse-1:N_mantisse];
        end
        if (a.exposant == '0 || b.exposant == '0) begin
            r = float_pack_res(a.signe ^ b.signe, E_ZERO, '0);
        end else begin
            r = float_pack_res(a.signe ^ b.signe, e, m);
        end
        return r;
    endfunction

    // Magnitude-ordered add with truncating alignment; exponent 0 is treated as zero.
    function automatic float float_add(input float a, input float b);
        float                         x;
        float                         y;
        float                         r;
        logic [N_exposant-1:0]        d;
        logic [N_mantisse+1:0]        mx;
        logic [N_mantisse+1:0]        my;
        logic [N_mantisse+1:0]        sum;
        logic signed [N_exposant+1:0] e;
        logic [N_mantisse-1:0]        m;
        if ({a.exposant, a.mantisse} >= {b.exposant, b.mantisse}) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x.exposant - y.exposant;
        mx = {2'b01, x.mantisse};
        my = {2'b01, y.mantisse} >> d;
        e  = $signed({2'b00, x.exposant});
        if (x.signe == y.signe) begin
            sum = mx + my;
            if (sum[N_mantisse+1]) begin
                m = sum[N_mantisse:1];
                e = e + E_ONE;
            end else begin
                m = sum[N_mantisse-1:0];
            end
        end else begin
            sum = mx - my;
            for (int i = 0; i < N_mantisse + 1; i++) begin
                if (!sum[N_mantisse] && sum != '0) begin
                    sum = sum << 1;
                    e   = e - E_ONE;
                end
            end
            m = sum[N_mantisse-1:0];
            if (sum == '0) begin
                e = E_ZERO;
            end
        end
        if (a.exposant == '0) begin
            r = b;
        end else if (b.exposant == '0) begin
            r = a;
        end else begin
            r = float_pack_res(x.signe, e, m);
        end
        return r;
    endfunction

    function automatic float float_sub(input float a, input float b);
        float nb;
        nb       = b;
        nb.signe = ~b.signe;
        return float_add(a, nb);
    endfunction
endpackage

module float_copro_seq
    import float_pack::*;
#(
    parameter int LAT_AS  = 2,
    parameter int LAT_MUL = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              op_i,
    input  logic [float_pack::W-1:0] a_i,
    input  logic [float_pack::W-1:0] b_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [float_pack::W-1:0] result_o
);
    localparam int W  = 1 + N_exposant + N_mantisse;
    localparam int CW = 16;
    localparam int NM = N_mantisse;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_DNORM, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  op_q, op_d;
    float                        a_q, a_d, b_q, b_d;
    float                        exec_res_q, exec_res_d, result_q, result_d;
    logic                        stage_q, stage_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NM+2:0]               rem_q, rem_d;
    logic [NM+1:0]               quo_q, quo_d;
    logic                        dsign_q, dsign_d, dzero_q, dzero_d, dsat_q, dsat_d;
    logic signed [N_exposant+1:0] dexp_q, dexp_d;

    float                        a_in_s, b_in_s, exec_val_s, div_res_s;
    logic [NM+2:0]               divisor_s, rem_sub_s;
    logic [NM-1:0]               norm_m_s;
    logic signed [N_exposant+1:0] norm_e_s;

    assign a_in_s = a_i;
    assign b_in_s = b_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (op_i == OP_DIV) ? S_DIV : S_EXEC;
                     else state_d = S_IDLE;
            S_EXEC:  if (stage_q && cnt_q == '0) state_d = S_DONE;
                     else state_d = S_EXEC;
            S_DIV:   if (cnt_q == '0) state_d = S_DNORM;
                     else state_d = S_DIV;
            S_DNORM: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
        result_o = result_q;
    end

    // Arithmetic evaluation, restoring-divide step and quotient normalisation
    always_comb begin
        case (op_q)
            OP_ADD:  exec_val_s = float_add(a_q, b_q);
            OP_SUB:  exec_val_s = float_sub(a_q, b_q);
            default: exec_val_s = float_mul(a_q, b_q);
        endcase
        divisor_s = {3'b001, b_q.mantisse};
        rem_sub_s = rem_q - divisor_s;
        if (quo_q[NM+1]) begin
            norm_m_s = quo_q[NM:1];
            norm_e_s = dexp_q;
        end else begin
            norm_m_s = quo_q[NM-1:0];
            norm_e_s = dexp_q - E_ONE;
        end
        if (dzero_q) begin
            div_res_s = float_pack_res(dsign_q, E_ZERO, '0);
        end else if (dsat_q) begin
            div_res_s = float_pack_res(dsign_q, E_SAT + E_ONE, '0);
        end else begin
            div_res_s = float_pack_res(dsign_q, norm_e_s, norm_m_s);
        end
    end

    // Datapath next-state
    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        exec_res_d = exec_res_q;
        result_d   = result_q;
        stage_d    = stage_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsign_d    = dsign_q;
        dexp_d     = dexp_q;
        dzero_d    = dzero_q;
        dsat_d     = dsat_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = a_in_s;
                    b_d     = b_in_s;
                    stage_d = 1'b0;
                    case (op_i)
                        OP_DIV:  cnt_d = CW'(NM + 1);
                        OP_MUL:  cnt_d = CW'(LAT_MUL - 2);
                        default: cnt_d = CW'(LAT_AS - 2);
                    endcase
                    rem_d   = {3'b001, a_in_s.mantisse};
                    quo_d   = '0;
                    dsign_d = a_in_s.signe ^ b_in_s.signe;
                    dexp_d  = $signed({2'b00, a_in_s.exposant})
                            - $signed({2'b00, b_in_s.exposant}) + E_BIAS;
                    dzero_d = (a_in_s.exposant == '0);
                    dsat_d  = (a_in_s.exposant != '0) && (b_in_s.exposant == '0);
                end else begin
                    stage_d = 1'b0;
                end
            end
            S_EXEC: begin
                // First EXEC cycle captures the arithmetic result; the rest only delay it.
                if (!stage_q) begin
                    stage_d    = 1'b1;
                    exec_res_d = exec_val_s;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    result_d = exec_res_q;
                end
            end
            S_DIV: begin
                if (rem_q >= divisor_s) begin
                    quo_d = {quo_q[NM:0], 1'b1};
                    rem_d = {rem_sub_s[NM+1:0], 1'b0};
                end else begin
                    quo_d = {quo_q[NM:0], 1'b0};
                    rem_d = {rem_q[NM+1:0], 1'b0};
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DNORM: result_d = div_res_s;
            S_DONE:  stage_d = 1'b0;
            default: stage_d = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            exec_res_q <= '0;
            result_q   <= '0;
            stage_q    <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsign_q    <= 1'b0;
            dexp_q     <= '0;
            dzero_q    <= 1'b0;
            dsat_q     <= 1'b0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            exec_res_q <= exec_res_d;
            result_q   <= result_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsign_q    <= dsign_d;
            dexp_q     <= dexp_d;
            dzero_q    <= dzero_d;
            dsat_q     <= dsat_d;
        end
    end
endmodule

// File: tb/tb_float_copro_seq.sv
// Directed bench for float_copro_seq: hand-computed results, latencies, dropped starts and abort.
module tb_float_copro_seq;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int tests_run = 0;
    int tests_failed = 0;

    float_copro_seq #(.LAT_AS(2), .LAT_MUL(2)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure edges from accept to done, check result and single pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        a_i     = 32'hDEADBEEF;
        b_i     = 32'h12345678;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result_o, exp_res);
        @(posedge clk_i);
        #1;
        check_eq({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'd0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("mul_1p5x2", 2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 2);
        run_op("mul_2x3",   2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 2);
        run_op("add_1p2",   2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 2);
        run_op("sub_3m1",   2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 2);
        run_op("add_m2p1",  2'd0, 32'hC0000000, 32'h3F800000, 32'hBF800000, 2);
        run_op("div_6d2",   2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 26);
        run_op("div_1d3",   2'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26);
        run_op("div_m1d0",  2'd3, 32'hBF800000, 32'h00000000, 32'hFF7FFFFF, 26);
        run_op("div_0d2",   2'd3, 32'h00000000, 32'h40000000, 32'h00000000, 26);

        // Starts pulsed during DIV and while done_o is high must be dropped.
        pulses = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'd3;
        a_i     = 32'h40C00000;
        b_i     = 32'h40000000;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            start_i = (c == 5) || done_o;
            op_i    = 2'd0;
            a_i     = 32'h3F800000;
            b_i     = 32'h3F800000;
            @(posedge clk_i);
            #1;
            if (done_o) pulses++;
        end
        start_i = 1'b0;
        check_eq("drop_pulses", 32'(pulses), 32'd1);
        check_eq("drop_result", result_o, 32'h40400000);
        check_eq("drop_idle", {31'd0, busy_o}, 32'd0);

        // Reset at edge 10 of a divide aborts it.
        pulses = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'd3;
        a_i     = 32'h40C00000;
        b_i     = 32'h40000000;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check_eq("abort_busy_pre", {31'd0, busy_o}, 32'd1);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) pulses++;
        end
        check_eq("abort_no_done", 32'(pulses), 32'd0);

        run_op("mul_after_rst", 2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
